// File: rtl/mlp_frame_driver_pkg.sv
// Shared types and frame geometry for the printed-MLP frame driver family.
// Frame widths live here so the bus interface and every driver variant agree.
package mlp_if_pkg;

  localparam int unsigned NUM_FEAT = 6;
  localparam int unsigned FEAT_W   = 4;
  localparam int unsigned CLS_W    = 2;
  localparam int unsigned IDX_W    = $clog2(NUM_FEAT);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_RESULT
  } drv_state_t;

endpackage

// File: rtl/mlp_frame_driver_if.sv
// Feature-in and class-out valid/ready channels of the frame driver.
// slave is the driver's view, master is the upstream/downstream environment.
interface mlp_frame_driver_if;
  import mlp_if_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [CLS_W-1:0]  m_class;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class
  );

endinterface

// File: rtl/mlp_frame_driver_settle_timer.sv
// Loadable down-counter that reports when it has reached zero.
// Shared by every classifier variant to time the combinational settle window.
module mlp_settle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mlp_frame_driver.sv
// Packs feature beats into a held frame for a combinational MLP, waits for it
// to settle, then returns the captured class on a valid/ready channel.
module mlp_frame_driver
  import mlp_if_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mlp_frame_driver_if.slave          bus,
  output logic [NUM_FEAT*FEAT_W-1:0] mlp_inp,
  input  logic [CLS_W-1:0]           mlp_out,
  output logic                       busy,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEAT - 1);

  drv_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [CLS_W-1:0] m_class_q;
  logic             beat;
  logic             last_slot;
  logic             frame_end;
  logic             settle_done;

  assign beat      = (state == ST_LOAD) && bus.s_valid;
  assign last_slot = (idx == LAST_IDX);
  assign frame_end = beat && last_slot && bus.s_last;

  // Handshake outputs decode registered state only, never an input.
  assign bus.s_ready = (state == ST_LOAD);
  assign bus.m_valid = (state == ST_RESULT);
  assign bus.m_class = m_class_q;
  assign busy        = !((state == ST_LOAD) && (idx == '0));

  mlp_settle_timer #(
    .CNT_W (8)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_end),
    .load_val (SETTLE_LOAD),
    .en       (state == ST_SETTLE),
    .done     (settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      idx       <= '0;
      mlp_inp   <= '0;
      m_class_q <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (beat) begin
            mlp_inp[FEAT_W*int'(idx) +: FEAT_W] <= bus.s_data;
            if (last_slot && bus.s_last) begin
              idx   <= '0;
              state <= ST_SETTLE;
            end else if (last_slot || bus.s_last) begin
              // Malformed frame: beat still consumed, written nibble kept.
              idx <= '0;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (settle_done) begin
            m_class_q <= mlp_out;
            state     <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (bus.m_ready) state <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_frame_driver.sv
// Directed + randomized bench for mlp_frame_driver with a stand-in classifier
// (class = sum of features mod 3) driving mlp_out from the held frame.
module tb_mlp_frame_driver;
  import mlp_if_pkg::*;

  localparam int unsigned SETTLE = 4;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_FEAT*FEAT_W-1:0] mlp_inp;
  logic [CLS_W-1:0]           mlp_out;
  logic                       busy;
  logic [7:0]                 err_cnt;

  mlp_frame_driver_if bus ();

  mlp_frame_driver #(
    .SETTLE_CYC (SETTLE),
    .ERR_W      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mlp_inp (mlp_inp),
    .mlp_out (mlp_out),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in classifier core attached to the held frame.
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < NUM_FEAT; i++) s += int'(mlp_inp[i*FEAT_W +: FEAT_W]);
    mlp_out = CLS_W'(s % 3);
  end

  int total = 0;
  int bad   = 0;

  // Reference model state, expressed as the list of nibbles per frame slot.
  logic [FEAT_W-1:0] shadow [NUM_FEAT];
  int                pos;
  int                err_m;
  bit                frame_ok;

  function automatic logic [NUM_FEAT*FEAT_W-1:0] model_frame();
    logic [NUM_FEAT*FEAT_W-1:0] r;
    r = '0;
    for (int i = NUM_FEAT - 1; i >= 0; i--) r = (r << FEAT_W) | (NUM_FEAT*FEAT_W)'(shadow[i]);
    return r;
  endfunction

  function automatic logic [CLS_W-1:0] model_class();
    int s;
    s = 0;
    foreach (shadow[i]) s += int'(shadow[i]);
    return CLS_W'(s % 3);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (shadow[i]) shadow[i] = '0;
    pos      = 0;
    err_m    = 0;
    frame_ok = 1'b0;
  endtask

  task automatic send_beat(input logic [FEAT_W-1:0] d, input bit l);
    int w;
    w = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("s_ready_wait", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    shadow[pos] = d;
    if (pos == NUM_FEAT - 1 && l) begin
      frame_ok = 1'b1;
      pos      = 0;
    end else if (l || pos == NUM_FEAT - 1) begin
      if (err_m < 255) err_m++;
      pos = 0;
    end else begin
      pos++;
    end
    check("beat_mlp_inp", 64'(mlp_inp), 64'(model_frame()));
    check("beat_err_cnt", 64'(err_cnt), 64'(err_m));
    check("beat_busy", 64'(busy), 64'(frame_ok || pos != 0));
  endtask

  task automatic send_frame(input logic [NUM_FEAT*FEAT_W-1:0] f);
    for (int i = 0; i < NUM_FEAT; i++) send_beat(f[i*FEAT_W +: FEAT_W], i == NUM_FEAT - 1);
  endtask

  task automatic get_result(input int hold);
    int n;
    n = 0;
    while (!bus.m_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(SETTLE));
    check("m_class", 64'(bus.m_class), 64'(model_class()));
    check("s_ready_result", 64'(bus.s_ready), 64'd0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data  = FEAT_W'($urandom);
      bus.s_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("hold_m_valid", 64'(bus.m_valid), 64'd1);
      check("hold_s_ready", 64'(bus.s_ready), 64'd0);
      check("hold_m_class", 64'(bus.m_class), 64'(model_class()));
      check("hold_mlp_inp", 64'(mlp_inp), 64'(model_frame()));
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    frame_ok    = 1'b0;
    check("done_m_valid", 64'(bus.m_valid), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
    check("done_mlp_inp", 64'(mlp_inp), 64'(model_frame()));
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mlp_inp", 64'(mlp_inp), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_class", 64'(bus.m_class), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_FEAT*FEAT_W-1:0] f;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("init_mlp_inp", 64'(mlp_inp), 64'd0);
    check("init_m_valid", 64'(bus.m_valid), 64'd0);
    check("init_m_class", 64'(bus.m_class), 64'd0);
    check("init_err_cnt", 64'(err_cnt), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    send_frame(24'h654321);
    check("frame_654321", 64'(mlp_inp), 64'h654321);
    get_result(0);

    send_frame(24'h000000);
    check("zero_frame_class", 64'(mlp_out), 64'd0);
    get_result(1);

    // Early s_last on beat 3, then a clean frame.
    send_beat(4'h7, 1'b0);
    send_beat(4'h8, 1'b0);
    send_beat(4'h9, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("early_last_no_valid", 64'(bus.m_valid), 64'd0);
    check("early_last_err", 64'(err_cnt), 64'd1);
    f = 24'($urandom);
    send_frame(f);
    get_result(2);

    // Six beats without s_last.
    for (int i = 0; i < NUM_FEAT; i++) send_beat(FEAT_W'($urandom), 1'b0);
    check("no_last_err", 64'(err_cnt), 64'd2);
    check("no_last_idle", 64'(busy), 64'd0);

    // Result held off for 20 cycles with stray beats offered.
    f = 24'($urandom);
    send_frame(f);
    get_result(20);

    for (int k = 0; k < 10; k++) begin
      f = 24'($urandom);
      send_frame(f);
      get_result(int'($urandom_range(0, 5)));
    end

    // Asynchronous reset in the middle of the settle window.
    f = 24'($urandom);
    send_frame(f);
    @(posedge clk);
    async_reset();

    // Asynchronous reset with three beats loaded.
    for (int i = 0; i < 3; i++) send_beat(FEAT_W'($urandom), 1'b0);
    check("mid_load_busy", 64'(busy), 64'd1);
    async_reset();
    f = 24'($urandom);
    send_frame(f);
    get_result(1);

    // Drive the error counter to saturation and one beyond.
    while (err_m < 255) send_beat(FEAT_W'($urandom), 1'b1);
    check("err_at_ff", 64'(err_cnt), 64'hFF);
    send_beat(FEAT_W'($urandom), 1'b1);
    check("err_saturated", 64'(err_cnt), 64'hFF);
    f = 24'($urandom);
    send_frame(f);
    get_result(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
